// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: fair tie-break, no preemption, combinational target mux.
// Optional watchdog that errors out a stalled transfer: define WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wishbone_m1_adr_o,
  input  logic [31:0] wishbone_m2_adr_o,
  input  logic [31:0] wishbone_m1_dat_o,
  input  logic [31:0] wishbone_m2_dat_o,
  input  logic [3:0]  wishbone_m1_sel_o,
  input  logic [3:0]  wishbone_m2_sel_o,
  input  logic        wishbone_m1_we_o,
  input  logic        wishbone_m2_we_o,
  input  logic        wishbone_m1_cyc_o,
  input  logic        wishbone_m2_cyc_o,
  input  logic        wishbone_m1_stb_o,
  input  logic        wishbone_m2_stb_o,
  output logic [31:0] wishbone_m1_dat_i,
  output logic [31:0] wishbone_m2_dat_i,
  output logic        wishbone_m1_ack_i,
  output logic        wishbone_m2_ack_i,
  output logic        wishbone_m1_err_i,
  output logic        wishbone_m2_err_i,
  output logic [31:0] wishbone_s_adr_i,
  output logic [31:0] wishbone_s_dat_i,
  output logic [3:0]  wishbone_s_sel_i,
  output logic        wishbone_s_we_i,
  output logic        wishbone_s_cyc_i,
  output logic        wishbone_s_stb_i,
  input  logic [31:0] wishbone_s_dat_o,
  input  logic        wishbone_s_ack_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_e;

  state_e state_q;
  logic   last_m2_q;
  logic   gnt1;
  logic   gnt2;
  logic   gnt_cyc;
  logic   gnt_stb;
  logic   timeout;

  assign gnt1    = (state_q == GNT1);
  assign gnt2    = (state_q == GNT2);
  assign gnt_cyc = (gnt1 & wishbone_m1_cyc_o) | (gnt2 & wishbone_m2_cyc_o);
  assign gnt_stb = (gnt1 & wishbone_m1_stb_o) | (gnt2 & wishbone_m2_stb_o);

  // Ties go to whichever master was not served last; a grant is held until its cyc drops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      last_m2_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (wishbone_m1_cyc_o && (!wishbone_m2_cyc_o || last_m2_q)) state_q <= GNT1;
          else if (wishbone_m2_cyc_o)                                  state_q <= GNT2;
        end
        GNT1: begin
          if (!wishbone_m1_cyc_o) begin
            last_m2_q <= 1'b0;
            state_q   <= wishbone_m2_cyc_o ? GNT2 : IDLE;
          end
        end
        GNT2: begin
          if (!wishbone_m2_cyc_o) begin
            last_m2_q <= 1'b1;
            state_q   <= wishbone_m1_cyc_o ? GNT1 : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // TIMEOUT must lie in 1..65535; anything else has no meaningful watchdog limit.
  if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_timeout_out_of_range
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = TIMEOUT[15:0];

  logic [15:0] wdog_q;

  assign timeout = (gnt1 | gnt2) && (wdog_q == TimeoutLimit);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                        wdog_q <= '0;
    else if (!gnt_cyc || wishbone_s_ack_o || timeout)      wdog_q <= '0;
    else if (gnt_stb)                                      wdog_q <= wdog_q + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign wishbone_s_adr_i = gnt1 ? wishbone_m1_adr_o : (gnt2 ? wishbone_m2_adr_o : '0);
  assign wishbone_s_dat_i = gnt1 ? wishbone_m1_dat_o : (gnt2 ? wishbone_m2_dat_o : '0);
  assign wishbone_s_sel_i = gnt1 ? wishbone_m1_sel_o : (gnt2 ? wishbone_m2_sel_o : '0);
  assign wishbone_s_we_i  = (gnt1 & wishbone_m1_we_o) | (gnt2 & wishbone_m2_we_o);
  assign wishbone_s_cyc_i = gnt_cyc & ~timeout;
  assign wishbone_s_stb_i = gnt_stb & ~timeout;

  // Read data is shared by both masters; only the grant owner sees ack or err.
  assign wishbone_m1_dat_i = sys_rst_n ? wishbone_s_dat_o : '0;
  assign wishbone_m2_dat_i = sys_rst_n ? wishbone_s_dat_o : '0;
  assign wishbone_m1_ack_i = gnt1 & wishbone_s_ack_o;
  assign wishbone_m2_ack_i = gnt2 & wishbone_s_ack_o;
  assign wishbone_m1_err_i = gnt1 & timeout;
  assign wishbone_m2_err_i = gnt2 & timeout;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic against
// an ownership-based reference model (watchdog checks follow WB_ARBITER_TIMEOUT_EN).
module tb_wb_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr  [1:2];
  logic [31:0] wdat [1:2];
  logic [3:0]  sel  [1:2];
  logic        we   [1:2];
  logic        cyc  [1:2];
  logic        stb  [1:2];
  logic [31:0] m1_dat, m2_dat;
  logic        m1_ack, m2_ack, m1_err, m2_err;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack;

  int errors;
  int checks;
  int owner;
  int lastServed;
  int wd;
  int seq[$];

  wb_arbiter #(.TIMEOUT(TMO)) dut (
    .sys_clk           (clk),
    .sys_rst_n         (rst_n),
    .wishbone_m1_adr_o (adr[1]),
    .wishbone_m2_adr_o (adr[2]),
    .wishbone_m1_dat_o (wdat[1]),
    .wishbone_m2_dat_o (wdat[2]),
    .wishbone_m1_sel_o (sel[1]),
    .wishbone_m2_sel_o (sel[2]),
    .wishbone_m1_we_o  (we[1]),
    .wishbone_m2_we_o  (we[2]),
    .wishbone_m1_cyc_o (cyc[1]),
    .wishbone_m2_cyc_o (cyc[2]),
    .wishbone_m1_stb_o (stb[1]),
    .wishbone_m2_stb_o (stb[2]),
    .wishbone_m1_dat_i (m1_dat),
    .wishbone_m2_dat_i (m2_dat),
    .wishbone_m1_ack_i (m1_ack),
    .wishbone_m2_ack_i (m2_ack),
    .wishbone_m1_err_i (m1_err),
    .wishbone_m2_err_i (m2_err),
    .wishbone_s_adr_i  (s_adr),
    .wishbone_s_dat_i  (s_wdat),
    .wishbone_s_sel_i  (s_sel),
    .wishbone_s_we_i   (s_we),
    .wishbone_s_cyc_i  (s_cyc),
    .wishbone_s_stb_i  (s_stb),
    .wishbone_s_dat_o  (s_rdat),
    .wishbone_s_ack_o  (s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit errNow();
`ifdef WB_ARBITER_TIMEOUT_EN
    return rst_n && owner != 0 && wd == int'(TMO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic resetModel();
    owner      = 0;
    lastServed = 2;
    wd         = 0;
  endtask

  // Reference: one owner at a time, kept until its cyc drops; ties favour the one not served last.
  task automatic modelStep();
    bit e;
    int other;
    if (!rst_n) begin
      resetModel();
      return;
    end
    e = errNow();
    if (owner == 0) begin
      if (cyc[1] && cyc[2]) owner = (lastServed == 1) ? 2 : 1;
      else if (cyc[1])      owner = 1;
      else if (cyc[2])      owner = 2;
      wd = 0;
    end else if (!cyc[owner]) begin
      lastServed = owner;
      other      = 3 - owner;
      owner      = cyc[other] ? other : 0;
      wd         = 0;
    end else if (s_ack || e) begin
      wd = 0;
    end else if (stb[owner]) begin
      wd++;
    end
  endtask

  task automatic checkOutput();
    int o;
    bit en;
    bit e;
    o  = (owner == 2) ? 2 : 1;
    en = rst_n && owner != 0;
    e  = errNow();
    chk("s_adr",  s_adr,        en ? adr[o] : 32'h0);
    chk("s_dat",  s_wdat,       en ? wdat[o] : 32'h0);
    chk("s_sel",  32'(s_sel),   en ? 32'(sel[o]) : 32'h0);
    chk("s_we",   32'(s_we),    32'(en && we[o]));
    chk("s_cyc",  32'(s_cyc),   32'(en && cyc[o] && !e));
    chk("s_stb",  32'(s_stb),   32'(en && stb[o] && !e));
    chk("m1_ack", 32'(m1_ack),  32'(en && owner == 1 && s_ack));
    chk("m2_ack", 32'(m2_ack),  32'(en && owner == 2 && s_ack));
    chk("m1_err", 32'(m1_err),  32'(en && owner == 1 && e));
    chk("m2_err", 32'(m2_err),  32'(en && owner == 2 && e));
    chk("m1_dat", m1_dat,       rst_n ? s_rdat : 32'h0);
    chk("m2_dat", m2_dat,       rst_n ? s_rdat : 32'h0);
  endtask

  task automatic randomizeBus();
    for (int m = 1; m <= 2; m++) begin
      adr[m]  = $urandom;
      wdat[m] = $urandom;
      sel[m]  = 4'($urandom);
      we[m]   = 1'($urandom);
    end
    s_rdat = $urandom;
  endtask

  task automatic applyStimulus(input bit c1, input bit s1, input bit c2, input bit s2, input bit ack);
    cyc[1] = c1;
    stb[1] = s1;
    cyc[2] = c2;
    stb[2] = s2;
    s_ack  = ack;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    for (int m = 1; m <= 2; m++) begin
      cyc[m] = 1'b0;
      stb[m] = 1'b0;
    end
    s_ack = 1'b0;
    resetModel();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    randomizeBus();
    doReset();

    adr[1] = 32'h10;
    we[1]  = 1'b0;
    s_rdat = 32'hCAFEBABE;
    applyStimulus(1, 1, 0, 0, 0);
    chk("single_idle_stb", 32'(s_stb), 32'h0);
    advance();
    applyStimulus(1, 1, 0, 0, 1);
    chk("single_stb", 32'(s_stb), 32'h1);
    chk("single_adr", s_adr, 32'h10);
    chk("single_m1_dat", m1_dat, 32'hCAFEBABE);
    chk("single_m1_ack", 32'(m1_ack), 32'h1);
    chk("single_m2_ack", 32'(m2_ack), 32'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 1);
    chk("late_ack_m1", 32'(m1_ack), 32'h1);
    advance();

    doReset();
    randomizeBus();
    applyStimulus(1, 1, 1, 1, 0);
    chk("tie_idle_cyc", 32'(s_cyc), 32'h0);
    advance();
    applyStimulus(1, 1, 1, 1, 1);
    chk("tie_m1_ack", 32'(m1_ack), 32'h1);
    chk("tie_m2_ack", 32'(m2_ack), 32'h0);
    advance();
    applyStimulus(0, 0, 1, 1, 0);
    advance();
    applyStimulus(0, 0, 1, 1, 1);
    chk("handover_cyc", 32'(s_cyc), 32'h1);
    chk("handover_m2_ack", 32'(m2_ack), 32'h1);
    advance();
    applyStimulus(0, 0, 0, 0, 0);
    advance();

    applyStimulus(1, 1, 0, 0, 0);
    advance();
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1, 1, 1, 1, 1);
      chk("burst_m1_ack", 32'(m1_ack), 32'h1);
      chk("burst_m2_ack", 32'(m2_ack), 32'h0);
      advance();
    end
    applyStimulus(0, 0, 1, 1, 0);
    advance();
    applyStimulus(0, 0, 1, 1, 1);
    chk("after_burst_m2_ack", 32'(m2_ack), 32'h1);
    advance();
    applyStimulus(0, 0, 0, 0, 0);
    advance();

    doReset();
    applyStimulus(1, 1, 1, 1, 0);
    advance();
    for (int k = 0; k < 12; k++) begin
      int cur;
      randomizeBus();
      applyStimulus(1, 1, 1, 1, 1);
      if (m1_ack)      seq.push_back(1);
      else if (m2_ack) seq.push_back(2);
      else             seq.push_back(0);
      cur = owner;
      advance();
      if (cur == 1) applyStimulus(0, 0, 1, 1, 0);
      else          applyStimulus(1, 1, 0, 0, 0);
      advance();
    end
    for (int k = 0; k < 12; k++) chk("alternate_grant", 32'(seq[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
    applyStimulus(0, 0, 0, 0, 0);
    advance();

    doReset();
    applyStimulus(0, 0, 1, 1, 0);
    advance();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 0, 1, 1, 0);
`ifdef WB_ARBITER_TIMEOUT_EN
      if (i == int'(TMO)) begin
        chk("stall_err_pulse", 32'(m2_err), 32'h1);
        chk("stall_stb_masked", 32'(s_stb), 32'h0);
      end else if (i < int'(TMO)) begin
        chk("stall_err_quiet", 32'(m2_err), 32'h0);
      end
`else
      chk("stall_err_zero", 32'(m2_err), 32'h0);
      chk("stall_stb_held", 32'(s_stb), 32'h1);
`endif
      advance();
    end
    applyStimulus(0, 0, 0, 0, 0);
    advance();

    doReset();
    for (int r = 0; r < 300; r++) begin
      bit c1, c2;
      randomizeBus();
      c1 = ($urandom_range(0, 3) != 0);
      c2 = ($urandom_range(0, 3) != 0);
      applyStimulus(c1, c1 && 1'($urandom), c2, c2 && 1'($urandom), ($urandom_range(0, 2) == 0));
      advance();
    end

    doReset();
    randomizeBus();
    s_rdat = 32'h12345678;
    applyStimulus(0, 0, 1, 1, 0);
    advance();
    applyStimulus(0, 0, 1, 1, 1);
    advance();
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    chk("midreset_s_cyc", 32'(s_cyc), 32'h0);
    chk("midreset_s_stb", 32'(s_stb), 32'h0);
    chk("midreset_s_adr", s_adr, 32'h0);
    chk("midreset_m2_ack", 32'(m2_ack), 32'h0);
    chk("midreset_m2_dat", m2_dat, 32'h0);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 1, 0);
    advance();
    applyStimulus(1, 1, 1, 1, 1);
    chk("post_reset_tie_m1", 32'(m1_ack), 32'h1);
    chk("post_reset_tie_m2", 32'(m2_ack), 32'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 0);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles (1..65535; used only with WB_ARBITER_TIMEOUT_EN).
REQ-002 SHALL have port sys_clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports wishbone_m1_adr_o, wishbone_m2_adr_o  in  32  master addresses.
REQ-005 SHALL have ports wishbone_m1_dat_o, wishbone_m2_dat_o  in  32  master write data.
REQ-006 SHALL have ports wishbone_m1_sel_o, wishbone_m2_sel_o  in  4  master byte selects.
REQ-007 SHALL have ports wishbone_m1_we_o, wishbone_m2_we_o, wishbone_m1_cyc_o, wishbone_m2_cyc_o, wishbone_m1_stb_o, wishbone_m2_stb_o  in  1 each  master control.
REQ-008 SHALL have ports wishbone_m1_dat_i, wishbone_m2_dat_i  out  32  read data to masters.
REQ-009 SHALL have ports wishbone_m1_ack_i, wishbone_m2_ack_i  out  1 each  acknowledge to masters.
REQ-010 SHALL have ports wishbone_m1_err_i, wishbone_m2_err_i  out  1 each  bus error to masters.
REQ-011 SHALL have ports wishbone_s_adr_i (32), wishbone_s_dat_i (32), wishbone_s_sel_i (4), wishbone_s_we_i, wishbone_s_cyc_i, wishbone_s_stb_i (1)  out  shared target-side bus.
REQ-012 SHALL have ports wishbone_s_dat_o (32), wishbone_s_ack_o (1)  in  target read data and acknowledge.

Function
REQ-013 SHALL implement registered FSM with states IDLE, GNT1, GNT2, plus a 1-bit last-served flag.
REQ-014 IDLE: only m1 cyc -> GNT1; only m2 cyc -> GNT2; both -> master not last served; neither -> stay IDLE.
REQ-015 GNTx: stay while granted master cyc=1, regardless of other requester (no preemption, multi-beat cycles atomic).
REQ-016 GNTx with granted cyc=0: go to GNTy if other cyc=1, else IDLE; set last-served=x on leaving GNTx.
REQ-017 Grant latency: request sampled in IDLE reaches target bus one cycle later; handover between masters adds no IDLE cycle.
REQ-018 Target adr/dat/sel/we/cyc/stb SHALL be combinational mux of granted master; in IDLE cyc=stb=we=0, adr/dat/sel=0.
REQ-019 wishbone_s_ack_o SHALL route combinationally only to granted master's ack_i; non-granted ack_i=0, err_i=0.
REQ-020 wishbone_s_dat_o SHALL be broadcast to both dat_i ports unconditionally.
REQ-021 Ack arriving in the cycle granted master drops cyc SHALL still be forwarded to that master.

Reset
REQ-022 sys_rst_n=0 SHALL immediately force IDLE, last-served=m2 (m1 wins first tie), watchdog count 0, all outputs 0, including mid-transfer.
REQ-023 Release of reset SHALL take effect on first rising sys_clk edge; no transfer is re-issued.

Configuration
REQ-024 Macro WB_ARBITER_TIMEOUT_EN defined: counter increments each cycle granted stb=1 and ack=0, clears on ack or grant change.
REQ-025 With macro, count reaching TIMEOUT SHALL pulse granted err_i for one cycle, suppress target cyc/stb that cycle, clear count; FSM then follows REQ-016.
REQ-026 Without macro: no counter, err_i tied 0, TIMEOUT unused, a stalled target holds the grant indefinitely.

Verification
REQ-027 Reset, m1 single read adr 0x10, target acks with 0xCAFEBABE -> target stb one cycle after request, m1 dat_i=0xCAFEBABE with ack, m2 ack=0.
REQ-028 Both cyc raised in same cycle after reset -> m1 granted first; m1 drops cyc -> m2 granted next edge, no IDLE cycle.
REQ-029 m1 holds cyc across 4 acked beats while m2 requests -> m2 waits all 4 beats, then granted.
REQ-030 Back-to-back contention 6 transfers each -> grants alternate m1,m2,m1,... exactly.
REQ-031 WB_ARBITER_TIMEOUT_EN, TIMEOUT=8, target never acks m2 -> m2 err_i pulses one cycle 8 cycles after stb, target stb low that cycle; without macro, stall persists 100 cycles, err_i=0.
REQ-032 sys_rst_n asserted mid m2 transfer -> all outputs 0 without clock; after release m1/m2 tie goes to m1.
